// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys derived on the fly
// (forward to round key 10, then backward), with byte S-box lookups computed over GF(2^8).

package aes_gf_pkg;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction
endpackage

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    import aes_gf_pkg::*;
    logic [7:0] inv;
    assign inv  = gf_inv(din);
    assign dout = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    import aes_gf_pkg::*;
    logic [7:0] pre;
    assign pre  = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05;
    assign dout = gf_inv(pre);
endmodule

module aes_inv_cipher_iter (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic         v_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);
    import aes_gf_pkg::*;

    typedef enum logic [1:0] {IDLE, KEYF, DEC, DONE} state_t;

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic         ready_q;
    logic         v_q;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return r;
    endfunction

    // Key schedule: the four S-boxes serve the forward step (SubWord of w3) and the
    // backward step (SubWord of the recovered w3 = w3' ^ w2').
    logic [31:0]  w0, w1, w2, w3, w3_prev;
    logic [31:0]  sub_in, sub_rot, sub_out, tw;
    logic [3:0]   rcon_idx;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] fwd_key, prev_key;

    assign {w0, w1, w2, w3} = rk;
    assign w3_prev  = w3 ^ w2;
    assign sub_in   = (state == DEC) ? w3_prev : w3;
    assign sub_rot  = {sub_in[23:0], sub_in[31:24]};
    assign rcon_idx = (state == DEC) ? rnd + 4'd1 : rnd;

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox u_sbox (.din(sub_rot[31-8*i -: 8]), .dout(sub_out[31-8*i -: 8]));
    end

    assign tw       = sub_out ^ {rcon(rcon_idx), 24'h0};
    assign n0       = w0 ^ tw;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign fwd_key  = {n0, n1, n2, n3};
    assign prev_key = {w0 ^ tw, w1 ^ w0, w2 ^ w1, w3_prev};

    // State round: InvShiftRows moves byte (r, c) to (r, c + r).
    logic [127:0] sr, isb, t, imc;

    // NOTE: every combinational output gets a default before any conditional or
    // partial assignment, so no path leaves it holding its old value (a latch).
    always_comb begin
        sr = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_inv_sbox u_inv_sbox (.din(sr[127-8*i -: 8]), .dout(isb[127-8*i -: 8]));
    end

    assign t   = isb ^ prev_key;
    assign imc = inv_mix(t);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            st      <= '0;
            rk      <= '0;
            rnd     <= '0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_i) begin
                        st      <= data_i;
                        rk      <= key_i;
                        rnd     <= 4'd1;
                        state   <= KEYF;
                        ready_q <= 1'b0;
                    end
                end
                KEYF: begin
                    rk <= fwd_key;
                    if (rnd == 4'd10) begin
                        st    <= st ^ fwd_key;
                        rnd   <= 4'd9;
                        state <= DEC;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DEC: begin
                    rk  <= prev_key;
                    rnd <= rnd - 4'd1;
                    if (rnd == 4'd0) begin
                        st    <= t;
                        state <= DONE;
                        v_q   <= 1'b1;
                    end else begin
                        st <= imc;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = st;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using the FIPS-197 C.1 and Appendix B vectors.

module tb_aes_inv_cipher_iter;
    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         v_i = 1'b0;
    logic         ready_o;
    logic [127:0] data_i = '0;
    logic [127:0] key_i = '0;
    logic         v_o;
    logic         ready_i = 1'b1;
    logic [127:0] data_o;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_inv_cipher_iter dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .key_i     (key_i),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .data_o    (data_o)
    );

    always #5 clk_i = ~clk_i;

    // Present one block for a single accept edge (block must be idle).
    task automatic start_block(input logic [127:0] key, input logic [127:0] ct);
        @(negedge clk_i);
        key_i  = key;
        data_i = ct;
        v_i    = 1'b1;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
    endtask

    // Count edges after accept until v_o; cyc = -1 on timeout. Captures rk after edge 10.
    task automatic wait_valid(output int cyc, output logic [127:0] rk10);
        int n;
        n    = 0;
        cyc  = -1;
        rk10 = '0;
        while (n < 60) begin
            @(posedge clk_i);
            #1;
            n++;
            if (n == 10) rk10 = dut.rk;
            if (v_o) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0;
        #12;
        total++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_o); else passed++;
        total++; if (v_o !== 1'b0) $display("FAIL reset_v got=%b exp=0", v_o); else passed++;
        total++; if (data_o !== 128'h0) $display("FAIL reset_data got=%h exp=0", data_o); else passed++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_c1;
        int cyc;
        logic [127:0] rk10;
        ready_i = 1'b1;
        start_block(C1_KEY, C1_CT);
        wait_valid(cyc, rk10);
        total++; if (cyc !== 20) $display("FAIL c1_latency got=%0d exp=20", cyc); else passed++;
        total++; if (data_o !== C1_PT) $display("FAIL c1_data got=%h exp=%h", data_o, C1_PT); else passed++;
        total++; if (rk10 !== C1_RK10) $display("FAIL c1_rk10 got=%h exp=%h", rk10, C1_RK10); else passed++;
        total++; if (ready_o !== 1'b0) $display("FAIL c1_ready_in_done got=%b exp=0", ready_o); else passed++;
        @(posedge clk_i);
        #1;
        total++; if (ready_o !== 1'b1) $display("FAIL c1_ready_after got=%b exp=1", ready_o); else passed++;
    endtask

    task automatic test_appendix_b;
        int cyc;
        logic [127:0] rk10;
        start_block(B_KEY, B_CT);
        wait_valid(cyc, rk10);
        total++; if (cyc !== 20) $display("FAIL b_latency got=%0d exp=20", cyc); else passed++;
        total++; if (data_o !== B_PT) $display("FAIL b_data got=%h exp=%h", data_o, B_PT); else passed++;
        total++; if (rk10 !== B_RK10) $display("FAIL b_rk10 got=%h exp=%h", rk10, B_RK10); else passed++;
        total++; if (dut.rk !== B_KEY) $display("FAIL b_rk_end got=%h exp=%h", dut.rk, B_KEY); else passed++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [127:0] rk10;
        ready_i = 1'b0;
        start_block(C1_KEY, C1_CT);
        wait_valid(cyc, rk10);
        total++; if (cyc !== 20) $display("FAIL bp_latency got=%0d exp=20", cyc); else passed++;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i);
            #1;
            total++; if (v_o !== 1'b1) $display("FAIL bp_v cyc=%0d got=%b exp=1", i, v_o); else passed++;
            total++; if (data_o !== C1_PT) $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, data_o, C1_PT); else passed++;
            total++; if (ready_o !== 1'b0) $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, ready_o); else passed++;
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        total++; if (ready_o !== 1'b1) $display("FAIL bp_ready_after got=%b exp=1", ready_o); else passed++;
        total++; if (v_o !== 1'b0) $display("FAIL bp_v_after got=%b exp=0", v_o); else passed++;
    endtask

    task automatic test_busy_ignored;
        int n;
        int cyc;
        start_block(C1_KEY, C1_CT);
        n   = 0;
        cyc = -1;
        while (n < 60) begin
            @(posedge clk_i);
            #1;
            n++;
            if (n == 3 || n == 14) begin
                v_i    = 1'b1;
                data_i = B_CT;
                key_i  = B_KEY;
            end else begin
                v_i = 1'b0;
            end
            if (v_o) begin
                cyc = n;
                break;
            end
        end
        v_i = 1'b0;
        total++; if (cyc !== 20) $display("FAIL busy_latency got=%0d exp=20", cyc); else passed++;
        total++; if (data_o !== C1_PT) $display("FAIL busy_data got=%h exp=%h", data_o, C1_PT); else passed++;
        @(posedge clk_i);
        #1;
        total++; if (ready_o !== 1'b1) $display("FAIL busy_idle got=%b exp=1", ready_o); else passed++;
    endtask

    task automatic test_reset_mid;
        start_block(B_KEY, B_CT);
        // After edge 14 the block is in DEC with rnd = 5.
        repeat (14) @(posedge clk_i);
        #2;
        total++; if (dut.rnd !== 4'd5) $display("FAIL mid_round got=%0d exp=5", dut.rnd); else passed++;
        reset_n_i = 1'b0;
        #1;
        total++; if (v_o !== 1'b0) $display("FAIL mid_v got=%b exp=0", v_o); else passed++;
        total++; if (ready_o !== 1'b1) $display("FAIL mid_ready got=%b exp=1", ready_o); else passed++;
        total++; if (data_o !== 128'h0) $display("FAIL mid_data got=%h exp=0", data_o); else passed++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        test_appendix_b();
    endtask

    task automatic test_back_to_back;
        int n;
        int v1;
        int v2;
        int acc2;
        logic [127:0] d1;
        logic [127:0] d2;
        ready_i = 1'b1;
        v1   = -1;
        v2   = -1;
        acc2 = -1;
        d1   = '0;
        d2   = '0;
        @(negedge clk_i);
        key_i  = C1_KEY;
        data_i = C1_CT;
        v_i    = 1'b1;
        @(posedge clk_i);
        #1;
        key_i  = B_KEY;
        data_i = B_CT;
        n = 0;
        while (n < 80) begin
            @(posedge clk_i);
            #1;
            n++;
            if (v_o && v1 < 0) begin
                v1 = n;
                d1 = data_o;
            end else if (v_o && acc2 > 0 && n > acc2) begin
                v2 = n;
                d2 = data_o;
                break;
            end
            if (n == acc2) v_i = 1'b0;
            if (acc2 < 0 && ready_o) acc2 = n + 1;
        end
        v_i = 1'b0;
        total++; if (v1 !== 20) $display("FAIL b2b_first_latency got=%0d exp=20", v1); else passed++;
        total++; if (d1 !== C1_PT) $display("FAIL b2b_first_data got=%h exp=%h", d1, C1_PT); else passed++;
        total++; if (acc2 !== 22) $display("FAIL b2b_second_accept got=%0d exp=22", acc2); else passed++;
        total++; if (v2 !== 42) $display("FAIL b2b_second_valid got=%0d exp=42", v2); else passed++;
        total++; if (d2 !== B_PT) $display("FAIL b2b_second_data got=%h exp=%h", d2, B_PT); else passed++;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        test_reset();
        test_c1();
        test_appendix_b();
        test_backpressure();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
